// File: rtl/matrix_operand_loader.sv
// matrix_operand_loader: debounced entry of 18 switch operands into matrices A and B, then start/wait handshake with the multiplier.
//   clk, rst (async, active-high)  | sw[7:0] operand value, btn_load / btn_clear raw buttons
//   mult_done  multiplier completion pulse
//   matrix_a/matrix_b[71:0] element k at [8k+7:8k] | start launch pulse | elem_idx next element (18 when full)
//   led_a / led_b / result_valid  state indicators
module matrix_operand_loader #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  sw,
  input  logic        btn_load,
  input  logic        btn_clear,
  input  logic        mult_done,
  output logic [71:0] matrix_a,
  output logic [71:0] matrix_b,
  output logic        start,
  output logic [4:0]  elem_idx,
  output logic        led_a,
  output logic        led_b,
  output logic        result_valid
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [2:0] {LOAD_A, LOAD_B, FIRE, WAIT, SHOW} state_t;
  state_t state;
  logic [1:0] btn_s1, btn_s2, level, level_q;
  logic [7:0] sw_s1, sw_s2;
  logic [CW-1:0] cnt [2];
  logic load_p, clear_p;
  logic [3:0] b_idx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      sw_s1 <= '0;
      sw_s2 <= '0;
      level_q <= '0;
    end else begin
      btn_s1 <= {btn_clear, btn_load};
      btn_s2 <= btn_s1;
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
      level_q <= level;
    end
  for (genvar i = 0; i < 2; i++) begin : g_db
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        cnt[i] <= '0;
        level[i] <= 1'b0;
      end else if (btn_s2[i] == level[i]) cnt[i] <= '0;
      else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt[i] <= '0;
        level[i] <= ~level[i];
      end else cnt[i] <= cnt[i] + 1'b1;
  end
  assign load_p = level[0] & ~level_q[0];
  assign clear_p = level[1] & ~level_q[1];
  // B slot = elem_idx - 9; 4-bit wraparound maps 16,17 onto 7,8
  assign b_idx = elem_idx[3:0] - 4'd9;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= LOAD_A;
      matrix_a <= '0;
      matrix_b <= '0;
      elem_idx <= '0;
    end else if (clear_p) begin
      state <= LOAD_A;
      matrix_a <= '0;
      matrix_b <= '0;
      elem_idx <= '0;
    end else
      case (state)
        LOAD_A: if (load_p) begin
          matrix_a[{elem_idx[3:0], 3'b000} +: 8] <= sw_s2;
          elem_idx <= elem_idx + 5'd1;
          if (elem_idx == 5'd8) state <= LOAD_B;
        end
        LOAD_B: if (load_p) begin
          matrix_b[{b_idx, 3'b000} +: 8] <= sw_s2;
          elem_idx <= elem_idx + 5'd1;
          if (elem_idx == 5'd17) state <= FIRE;
        end
        FIRE: state <= WAIT;
        WAIT: if (mult_done) state <= SHOW;
        default: state <= state;
      endcase
  assign start = state == FIRE;
  assign led_a = state == LOAD_A;
  assign led_b = state == LOAD_B;
  assign result_valid = state == SHOW;
endmodule

// File: tb/tb_matrix_operand_loader.sv
// tb_matrix_operand_loader: table, directed and random checks of matrix_operand_loader against a byte-array model.
module tb_matrix_operand_loader;
  logic clk = 0, rst = 1, btn_load = 0, btn_clear = 0, mult_done = 0;
  logic [7:0] sw = 0;
  logic [71:0] matrix_a, matrix_b;
  logic start, led_a, led_b, result_valid;
  logic [4:0] elem_idx;
  int checks = 0, failures = 0;
  int start_cnt = 0, exp_starts = 0, wide_start = 0;
  logic start_prev = 0;
  logic [7:0] ma [9], mb [9];
  int m_idx = 0, m_st = 0;
  typedef struct {int op; logic [7:0] val; logic [4:0] exp_idx; logic exp_la, exp_lb, exp_rv;} vec_t;
  vec_t vecs [19];

  matrix_operand_loader #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn_load(btn_load), .btn_clear(btn_clear), .mult_done(mult_done),
    .matrix_a(matrix_a), .matrix_b(matrix_b), .start(start), .elem_idx(elem_idx),
    .led_a(led_a), .led_b(led_b), .result_valid(result_valid));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (start) start_cnt <= start_cnt + 1;
    if (start && start_prev) wide_start <= wide_start + 1;
    start_prev <= start;
  end

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < 9; k++) begin ma[k] = 0; mb[k] = 0; end
    m_idx = 0;
    m_st = 0;
  endtask

  task automatic m_load(input logic [7:0] v);
    if (m_st == 0) begin
      ma[m_idx] = v;
      m_idx++;
      if (m_idx == 9) m_st = 1;
    end else if (m_st == 1) begin
      mb[m_idx - 9] = v;
      m_idx++;
      if (m_idx == 18) begin m_st = 2; exp_starts++; end
    end
  endtask

  task automatic check_all(input string tag);
    logic [71:0] ea, eb;
    for (int k = 0; k < 9; k++) begin ea[8*k +: 8] = ma[k]; eb[8*k +: 8] = mb[k]; end
    chk({tag, ".matrix_a"}, matrix_a, ea);
    chk({tag, ".matrix_b"}, matrix_b, eb);
    chk({tag, ".elem_idx"}, 72'(elem_idx), 72'(m_idx));
    chk({tag, ".leds"}, 72'({led_a, led_b, result_valid}), 72'({m_st == 0, m_st == 1, m_st == 3}));
    chk({tag, ".starts"}, 72'(start_cnt), 72'(exp_starts));
    chk({tag, ".start_width"}, 72'(wide_start), 72'(0));
  endtask

  task automatic press_load(input logic [7:0] v, input int hold);
    sw = v;
    btn_load = 1;
    repeat (hold) @(negedge clk);
    btn_load = 0;
    repeat (12) @(negedge clk);
    m_load(v);
  endtask

  task automatic press_clear(input logic with_load);
    btn_clear = 1;
    btn_load = with_load;
    repeat (12) @(negedge clk);
    btn_clear = 0;
    btn_load = 0;
    repeat (12) @(negedge clk);
    m_reset();
  endtask

  task automatic pulse_done();
    mult_done = 1;
    @(negedge clk);
    mult_done = 0;
    repeat (3) @(negedge clk);
    if (m_st == 2) m_st = 3;
  endtask

  initial begin
    m_reset();
    for (int k = 0; k < 18; k++)
      vecs[k] = '{0, 8'(k + 1), 5'(k + 1), k < 8, k >= 8 && k < 17, 1'b0};
    vecs[18] = '{2, 8'h00, 5'd18, 1'b0, 1'b0, 1'b1};
    repeat (3) @(negedge clk);
    check_all("reset");
    rst = 0;
    @(negedge clk);

    for (int i = 0; i < 19; i++) begin
      if (vecs[i].op == 0) press_load(vecs[i].val, 12);
      else pulse_done();
      chk($sformatf("vec%0d.idx", i), 72'(elem_idx), 72'(vecs[i].exp_idx));
      chk($sformatf("vec%0d.leds", i), 72'({led_a, led_b, result_valid}),
          72'({vecs[i].exp_la, vecs[i].exp_lb, vecs[i].exp_rv}));
    end
    chk("full.a", matrix_a, 72'h090807060504030201);
    chk("full.b", matrix_b, 72'h1211100F0E0D0C0B0A);
    chk("full.starts", 72'(start_cnt), 72'(1));
    check_all("full");

    press_clear(0);
    check_all("clear");
    sw = 8'hA5;
    for (int c = 0; c < 20; c++) begin
      btn_load = (c % 5) < 3;
      @(negedge clk);
    end
    btn_load = 1;
    repeat (10) @(negedge clk);
    btn_load = 0;
    repeat (12) @(negedge clk);
    m_load(8'hA5);
    check_all("bounce");

    press_load(8'h3C, 1000);
    check_all("held");

    press_load(8'h11, 12);
    press_load(8'h22, 12);
    press_load(8'h33, 12);
    chk("prio.pre_idx", 72'(elem_idx), 72'(5));
    sw = 8'h77;
    press_clear(1);
    check_all("prio");

    for (int k = 0; k < 18; k++) press_load(8'($urandom), 12);
    check_all("abandon.wait");
    press_clear(0);
    pulse_done();
    check_all("abandon");

    for (int k = 0; k < 12; k++) press_load(8'($urandom), 12);
    check_all("pre_rst");
    #2 rst = 1;
    #1;
    m_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    press_load(8'h5A, 12);
    chk("rst.restart", matrix_a, 72'h5A);
    check_all("restart");

    for (int i = 0; i < 40; i++) begin
      int r = $urandom_range(0, 9);
      if (r < 7) press_load(8'($urandom), 12);
      else if (r == 7) press_clear(0);
      else pulse_done();
      check_all($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/matrix_operand_loader.md
# matrix_operand_loader

Operand-entry front end for the 3x3 parallel multiplier. It debounces the board buttons and captures eighteen 8-bit operands from the switches, nine for matrix A and then nine for matrix B. Once both matrices are loaded it issues a one-cycle start pulse to the multiplier and waits for completion. It is the writer side of the result display path: it packs elements with the same flattened c0..c8 layout that the display consumes.

## Interface
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles required before a button level is accepted (10 ms at 100 MHz).
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- sw  in  8  operand value, unsigned, asynchronous to clk
- btn_load  in  1  raw push-button; each press stores one element
- btn_clear  in  1  raw push-button; discards all operands and restarts entry
- mult_done  in  1  one-cycle pulse from the multiplier when the result is valid
- matrix_a  out  72  element k at [8k+7:8k], k = 0..8, row-major
- matrix_b  out  72  same packing as matrix_a
- start  out  1  one-cycle pulse that launches the multiplication
- elem_idx  out  5  index of the next element to be written (0..17); holds 18 once entry is complete
- led_a  out  1  high in LOAD_A
- led_b  out  1  high in LOAD_B
- result_valid  out  1  high in SHOW

## Operation
- **Input conditioning:** each button passes through a 2-flop synchronizer, then a debouncer.
  - The debouncer has a counter and a debounced level register.
  - When the synced bit differs from the level, the counter increments. The counter resets to 0 on any cycle where they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 while they still differ, the level toggles and the counter resets.
  - A rising edge of the level produces a one-cycle press pulse (load_p, clear_p). A held button produces exactly one pulse.
- **sw conditioning:** sw is 2-flop synchronized. It is sampled on the same edge that consumes load_p.
- **FSM states:** LOAD_A, LOAD_B, FIRE, WAIT, SHOW.
  - LOAD_A: on load_p, write sw into matrix_a[8*idx +: 8] and increment elem_idx. If idx was 8, go to LOAD_B.
  - LOAD_B: on load_p, write sw into matrix_b[8*(idx-9) +: 8] and increment elem_idx. If idx was 17, elem_idx becomes 18 and the FSM goes to FIRE.
  - FIRE: start=1 for exactly this cycle, then go to WAIT.
  - WAIT: on mult_done, go to SHOW. load_p is ignored.
  - SHOW: matrices and elem_idx hold. load_p is ignored.
- **Clear:** in any state, clear_p zeroes both matrices, sets elem_idx=0 and goes to LOAD_A on the next edge.
  - If clear_p and load_p occur in the same cycle, clear wins and the load is discarded.
  - Clear during WAIT abandons the run; a later mult_done is ignored because the FSM is no longer in WAIT.
- **Ignored events:** mult_done outside WAIT is ignored. A mult_done in the same cycle as FIRE is ignored.
- **Data width:** operands are written verbatim, 8 bits unsigned, with no arithmetic performed.
- **Write masking:** only the addressed byte changes on a write.

## Timing
- **Reset values:** state LOAD_A, matrix_a=0, matrix_b=0, elem_idx=0, start=0, led_a=1, led_b=0, result_valid=0. Debounce counters and levels are 0 and synchronizers are 0.
- **Press latency:** a clean press produces load_p DEBOUNCE_CYCLES+2 cycles after the button input first goes high (2 synchronizer cycles, then the debounce count).
  - The element register updates on the edge where load_p=1, so it is visible one cycle after load_p.
- **Release:** release is debounced the same way. A bounce shorter than DEBOUNCE_CYCLES never changes the level.
- **Start pulse:** the ninth B write moves the FSM to FIRE at the following edge. start is registered high during the FIRE cycle and low otherwise; it is never more than one cycle wide.
- **Status outputs:** all outputs are registered, and led_a, led_b and result_valid are decoded from the state register.
- **Mid-operation reset:** asserting rst at any point returns every output to its reset value immediately (asynchronous). Deassertion is synchronous to clk; the block is in LOAD_A on the first edge after release.

## Test plan
- **Full entry:** DEBOUNCE_CYCLES=4. Enter values 1..9 for A and 10..18 for B with clean presses.
  - Required: matrix_a=0x090807060504030201 and matrix_b=0x121110_0F0E0D0C0B0A.
  - Required: start is high for exactly 1 cycle, then elem_idx=18.
  - Required: a mult_done pulse afterwards gives result_valid=1.
- **Bounce rejection:** pulse btn_load high for 3 cycles, low for 2, then high for 3, repeated for 20 cycles, then hold high for 10 cycles.
  - Required: exactly one write, and elem_idx goes 0 to 1.
- **Held button:** hold btn_load high for 1000 cycles.
  - Required: exactly one element written.
- **Clear priority:** after 5 A writes, make btn_clear and btn_load rise together.
  - Required: both matrices = 0, elem_idx=0, state LOAD_A, and the load is discarded.
- **Abandoned run:** enter all 18 elements, clear during WAIT, then pulse mult_done.
  - Required: result_valid stays 0 and the state stays LOAD_A.
- **Async reset:** assert rst mid-LOAD_B at idx 12.
  - Required: all outputs go to their reset values in the same cycle.
  - Required: entry restarts at matrix_a[7:0].
